// File: rtl/md_ring_pkg.sv
// Shared types and helpers for the force-writeback ring: default packet
// geometry, the packed packet layout, and small field/counter helpers.
package md_ring_pkg;

    localparam int NUM_CELLS         = 64;
    localparam int DATA_WIDTH        = 32;
    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int NODE_ID_WIDTH     = $clog2(NUM_CELLS);
    localparam int FORCE_DATA_WIDTH  = 3*DATA_WIDTH + PARTICLE_ID_WIDTH;
    localparam int PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH;

    // Destination sits in the MSBs; the remainder is the ejected payload.
    typedef struct packed {
        logic [NODE_ID_WIDTH-1:0]     dst;
        logic [PARTICLE_ID_WIDTH-1:0] pid;
        logic [DATA_WIDTH-1:0]        fx;
        logic [DATA_WIDTH-1:0]        fy;
        logic [DATA_WIDTH-1:0]        fz;
    } ring_pkt_t;

    function automatic logic [NODE_ID_WIDTH-1:0] pkt_dst(input ring_pkt_t p);
        return p.dst;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            return v + 32'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/ring_inj_fifo.sv
// Injection FIFO for one ring stop: show-ahead head, registered count-derived
// full/empty flags. A write while full is dropped even if a read occurs.
module ring_inj_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    import md_ring_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic             full_r;
    logic             empty_r;
    logic             do_wr_s;
    logic             do_rd_s;

    assign do_wr_s = wr_en && !full_r;
    assign do_rd_s = rd_en && !empty_r;
    assign head    = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;

    // Next occupancy from the accepted write/read pair.
    always_comb begin
        count_nx_s = count_r;
        case ({do_wr_s, do_rd_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Storage array; contents need no reset since flags gate every read.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, count and flags; pointers wrap naturally at a power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CW'(DEPTH));
            empty_r <= (count_nx_s == CW'(0));
        end
    end

endmodule

// File: rtl/ring_station.sv
// One stop of the unidirectional force-writeback ring: transit forwarding,
// local injection into free slots, and ejection to the force cache.
// Optional statistics counters are built when RING_STATION_STATS_EN is defined.
module ring_station #(
    parameter int NUM_CELLS         = 64,
    parameter int NODE_ID           = 0,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
    parameter int FORCE_DATA_WIDTH  = 3*DATA_WIDTH + PARTICLE_ID_WIDTH,
    parameter int PACKET_WIDTH      = FORCE_DATA_WIDTH + NODE_ID_WIDTH,
    parameter int INJ_FIFO_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PACKET_WIDTH-1:0]     local_pkt_in,
    input  logic                        local_pkt_valid,
    output logic                        local_ready,
    input  logic [PACKET_WIDTH-1:0]     ring_in,
    input  logic                        ring_in_valid,
    output logic [PACKET_WIDTH-1:0]     ring_out,
    output logic                        ring_out_valid,
    output logic [FORCE_DATA_WIDTH-1:0] eject_data,
    output logic                        eject_valid,
    output logic                        injection_empty,
    output logic [4*32-1:0]             stat_count
);
    import md_ring_pkg::*;

    localparam logic [NODE_ID_WIDTH-1:0] MY_ID = NODE_ID_WIDTH'(NODE_ID);

    logic [PACKET_WIDTH-1:0]     head_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic                        pop_s;
    logic                        ring_hit_s;
    logic                        head_hit_s;

    logic [PACKET_WIDTH-1:0]     ring_out_nx_s;
    logic                        ring_out_valid_nx_s;
    logic [FORCE_DATA_WIDTH-1:0] eject_data_nx_s;
    logic                        eject_valid_nx_s;

    logic [PACKET_WIDTH-1:0]     ring_out_r;
    logic                        ring_out_valid_r;
    logic [FORCE_DATA_WIDTH-1:0] eject_data_r;
    logic                        eject_valid_r;

    ring_inj_fifo #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (INJ_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (local_pkt_valid),
        .wr_data (local_pkt_in),
        .rd_en   (pop_s),
        .head    (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign ring_hit_s      = (ring_in[PACKET_WIDTH-1 -: NODE_ID_WIDTH] == MY_ID);
    assign head_hit_s      = !fifo_empty_s && (head_s[PACKET_WIDTH-1 -: NODE_ID_WIDTH] == MY_ID);
    assign local_ready     = !fifo_full_s;
    assign injection_empty = fifo_empty_s && !local_pkt_valid;

    assign ring_out        = ring_out_r;
    assign ring_out_valid  = ring_out_valid_r;
    assign eject_data      = eject_data_r;
    assign eject_valid     = eject_valid_r;

    // Slot arbitration: ring traffic first, then the FIFO head. Idle data is zeroed.
    always_comb begin
        ring_out_nx_s       = '0;
        ring_out_valid_nx_s = 1'b0;
        eject_data_nx_s     = '0;
        eject_valid_nx_s    = 1'b0;
        pop_s               = 1'b0;
        if (ring_in_valid && ring_hit_s) begin
            eject_valid_nx_s = 1'b1;
            eject_data_nx_s  = ring_in[FORCE_DATA_WIDTH-1:0];
            // The freed slot takes the head unless it also wants the busy eject port.
            if (!fifo_empty_s && !head_hit_s) begin
                ring_out_nx_s       = head_s;
                ring_out_valid_nx_s = 1'b1;
                pop_s               = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else if (ring_in_valid) begin
            ring_out_nx_s       = ring_in;
            ring_out_valid_nx_s = 1'b1;
        end else if (!fifo_empty_s) begin
            pop_s = 1'b1;
            if (head_hit_s) begin
                eject_valid_nx_s = 1'b1;
                eject_data_nx_s  = head_s[FORCE_DATA_WIDTH-1:0];
            end else begin
                ring_out_nx_s       = head_s;
                ring_out_valid_nx_s = 1'b1;
            end
        end else begin
            ring_out_valid_nx_s = 1'b0;
            eject_valid_nx_s    = 1'b0;
        end
    end

    // Registered ring and eject outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_out_r       <= '0;
            ring_out_valid_r <= 1'b0;
            eject_data_r     <= '0;
            eject_valid_r    <= 1'b0;
        end else begin
            ring_out_r       <= ring_out_nx_s;
            ring_out_valid_r <= ring_out_valid_nx_s;
            eject_data_r     <= eject_data_nx_s;
            eject_valid_r    <= eject_valid_nx_s;
        end
    end

`ifdef RING_STATION_STATS_EN
    logic        inject_ev_s;
    logic        eject_ev_s;
    logic        fwd_ev_s;
    logic        stall_ev_s;
    logic [31:0] stat_inject_r;
    logic [31:0] stat_eject_r;
    logic [31:0] stat_fwd_r;
    logic [31:0] stat_stall_r;

    // Event decode from the same-cycle arbitration decision.
    always_comb begin
        inject_ev_s = pop_s && !head_hit_s;
        eject_ev_s  = eject_valid_nx_s;
        fwd_ev_s    = ring_in_valid && !ring_hit_s;
        stall_ev_s  = ring_in_valid && !ring_hit_s && !fifo_empty_s;
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_inject_r <= 32'd0;
            stat_eject_r  <= 32'd0;
            stat_fwd_r    <= 32'd0;
            stat_stall_r  <= 32'd0;
        end else begin
            stat_inject_r <= sat_inc32(stat_inject_r, inject_ev_s);
            stat_eject_r  <= sat_inc32(stat_eject_r,  eject_ev_s);
            stat_fwd_r    <= sat_inc32(stat_fwd_r,    fwd_ev_s);
            stat_stall_r  <= sat_inc32(stat_stall_r,  stall_ev_s);
        end
    end

    assign stat_count = {stat_stall_r, stat_fwd_r, stat_eject_r, stat_inject_r};
`else
    assign stat_count = '0;
`endif

endmodule
